// File: rtl/alu_exec_unit_if.sv
// Request/result bundle between the ID/EX stage and the execution ALU.
// The slave side is the ALU; the master side is the pipeline (or a bench).
interface alu_exec_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid_i;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;
    logic             done_o;
    logic             busy_o;
    logic             stall_o;

    modport slave (
        input  valid_i, ALUCtrl_i, data1_i, data2_i,
        output data_o, zero_o, done_o, busy_o, stall_o
    );

    modport master (
        output valid_i, ALUCtrl_i, data1_i, data2_i,
        input  data_o, zero_o, done_o, busy_o, stall_o
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle and/or/add/sub plus an iterative
// shift-add multiplier that stalls the pipeline for WIDTH cycles.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    alu_exec_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b011;

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_data,   w_data_nxt;
    logic             r_zero,   w_zero_nxt;
    logic             r_done,   w_done_nxt;
    logic [WIDTH-1:0] r_mcand,  w_mcand_nxt;
    logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
    logic [WIDTH-1:0] r_acc,    w_acc_nxt;
    logic [CW-1:0]    r_cnt,    w_cnt_nxt;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_add;
    logic [WIDTH-1:0] w_alu_res;

    assign w_accept  = (r_state == S_IDLE) && bus.valid_i;
    assign w_last    = (r_state == S_MUL) && (r_cnt == CW'(WIDTH - 1));
    assign w_acc_add = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && bus.ALUCtrl_i == OP_MUL) w_state_nxt = S_MUL;
            S_MUL:  if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Single-cycle result mux; undefined codes yield zero
    always_comb begin
        w_alu_res = '0;
        case (bus.ALUCtrl_i)
            OP_AND:  w_alu_res = bus.data1_i & bus.data2_i;
            OP_OR:   w_alu_res = bus.data1_i | bus.data2_i;
            OP_ADD:  w_alu_res = bus.data1_i + bus.data2_i;
            OP_SUB:  w_alu_res = bus.data1_i - bus.data2_i;
            default: w_alu_res = '0;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        w_data_nxt   = r_data;
        w_zero_nxt   = r_zero;
        w_done_nxt   = 1'b0;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.ALUCtrl_i == OP_MUL) begin
                        w_mcand_nxt  = bus.data1_i;
                        w_mplier_nxt = bus.data2_i;
                        w_acc_nxt    = '0;
                        w_cnt_nxt    = '0;
                    end else begin
                        w_data_nxt = w_alu_res;
                        w_zero_nxt = (w_alu_res == '0);
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_MUL: begin
                w_acc_nxt    = w_acc_add;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt + CW'(1);
                if (w_last) begin
                    w_data_nxt = w_acc_add;
                    w_zero_nxt = (w_acc_add == '0);
                    w_done_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data   <= '0;
            r_zero   <= 1'b1;
            r_done   <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            r_data   <= w_data_nxt;
            r_zero   <= w_zero_nxt;
            r_done   <= w_done_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign bus.data_o  = r_data;
    assign bus.zero_o  = r_zero;
    assign bus.done_o  = r_done;
    assign bus.busy_o  = (r_state == S_MUL);
    // Stall must rise in the issue cycle, before the MUL state is entered
    assign bus.stall_o = (r_state == S_MUL)
                       | (bus.valid_i & (bus.ALUCtrl_i == OP_MUL) & (r_state == S_IDLE));
endmodule
